axi_stream_checker: RTL and testbench

AXI_STREAM_CHECKER -- requirements
Module: axi_stream_checker

---
 rtl/axi_stream_checker.sv | 160 ++++++++++++++++
 tb/tb_axi_stream_checker.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_checker.sv
// AXI-Stream sink that paces tready with an optional pause after each beat and
// checks an incrementing data pattern, start-of-packet tuser[0] and tlast framing.
module axi_stream_checker #(
  parameter int unsigned BYTES     = 1,
  parameter int unsigned USER_W    = 1,
  parameter int unsigned PKT_LEN   = 16,
  parameter int unsigned PAUSE_CNT = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [BYTES*8-1:0]   s_tdata,
  input  logic                 s_tvalid,
  input  logic                 s_tlast,
  input  logic [USER_W-1:0]    s_tuser,
  output logic                 s_tready,
  input  logic                 enable,
  input  logic                 clr,
  output logic [31:0]          pkt_cnt,
  output logic [31:0]          beat_cnt,
  output logic [31:0]          err_cnt,
  output logic                 err_flag
);

  localparam int unsigned W   = BYTES * 8;
  localparam int unsigned PCW = (PAUSE_CNT > 1) ? $clog2(PAUSE_CNT) : 1;
  localparam logic [PCW-1:0] PCNT_LAST = PCW'((PAUSE_CNT > 0) ? PAUSE_CNT - 1 : 0);
  localparam logic [15:0]    IDX_LAST  = 16'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READY,
    ST_PAUSE
  } state_e;

  state_e             state_q, state_d;
  logic [PCW-1:0]     pcnt_q, pcnt_d;
  logic               armed_q;
  logic               tready_q;

  logic [W-1:0]       exp_q, exp_d;
  logic [15:0]        idx_q, idx_d;
  logic [31:0]        pkt_cnt_q, pkt_cnt_d;
  logic [31:0]        beat_cnt_q, beat_cnt_d;
  logic [31:0]        err_cnt_q, err_cnt_d;
  logic               err_flag_q, err_flag_d;

  logic               beat;
  logic               data_err;
  logic               user_err;
  logic               last_err;
  logic               any_err;
  logic               unused_tuser;

  // Only tuser[0] carries meaning; upper sideband bits are deliberately ignored.
  assign unused_tuser = ^s_tuser;

  assign beat = s_tvalid && tready_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  // armed_q delays leaving IDLE by one edge after reset release, so tready
  // cannot rise before the second edge.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (armed_q) state_d = ST_READY;
        end
        ST_READY: begin
          if (beat && (PAUSE_CNT > 0)) begin
            state_d = ST_PAUSE;
            pcnt_d  = '0;
          end
        end
        ST_PAUSE: begin
          if (pcnt_q == PCNT_LAST) state_d = ST_READY;
          else                     pcnt_d  = pcnt_q + 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      pcnt_q   <= '0;
      armed_q  <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      armed_q  <= 1'b1;
      tready_q <= (state_d == ST_READY);
    end
  end

  assign data_err = (s_tdata != exp_q);
  assign user_err = (s_tuser[0] != (idx_q == '0));
  assign last_err = (s_tlast != (idx_q == IDX_LAST));
  assign any_err  = data_err || user_err || last_err;

  // clr has priority over a beat accepted on the same edge.
  always_comb begin
    exp_d      = exp_q;
    idx_d      = idx_q;
    pkt_cnt_d  = pkt_cnt_q;
    beat_cnt_d = beat_cnt_q;
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    if (clr) begin
      exp_d      = '0;
      idx_d      = '0;
      pkt_cnt_d  = '0;
      beat_cnt_d = '0;
      err_cnt_d  = '0;
      err_flag_d = 1'b0;
    end else if (beat) begin
      exp_d      = s_tdata + W'(1);
      idx_d      = (s_tlast || (idx_q == IDX_LAST)) ? '0 : idx_q + 16'd1;
      beat_cnt_d = sat_inc(beat_cnt_q);
      if (s_tlast) pkt_cnt_d = sat_inc(pkt_cnt_q);
      if (any_err) begin
        err_cnt_d  = sat_inc(err_cnt_q);
        err_flag_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q      <= '0;
      idx_q      <= '0;
      pkt_cnt_q  <= '0;
      beat_cnt_q <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
    end else begin
      exp_q      <= exp_d;
      idx_q      <= idx_d;
      pkt_cnt_q  <= pkt_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign s_tready = tready_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign beat_cnt = beat_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign err_flag = err_flag_q;

endmodule

// File: tb/tb_axi_stream_checker.sv
// Bench for axi_stream_checker: two instances (no pause / pause of 2) compared
// every cycle against a behavioural model, plus directed scenarios with literal expectations.
module tb_axi_stream_checker;

  localparam int LEN = 4;
  localparam int P0  = 0;
  localparam int P2  = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic        clr = 1'b0;

  logic [7:0]  dat    [2];
  logic        vld    [2];
  logic        lst    [2];
  logic [1:0]  usr    [2];
  logic        rdy_o  [2];
  logic [31:0] pkt_o  [2];
  logic [31:0] beat_o [2];
  logic [31:0] err_o  [2];
  logic        flag_o [2];

  int checks   = 0;
  int failures = 0;
  int stalls0  = 0;

  always #5 clk = ~clk;

  axi_stream_checker #(.BYTES(1), .USER_W(2), .PKT_LEN(LEN), .PAUSE_CNT(P0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .s_tdata(dat[0]), .s_tvalid(vld[0]), .s_tlast(lst[0]),
    .s_tuser(usr[0]), .s_tready(rdy_o[0]), .enable(enable), .clr(clr),
    .pkt_cnt(pkt_o[0]), .beat_cnt(beat_o[0]), .err_cnt(err_o[0]), .err_flag(flag_o[0])
  );

  axi_stream_checker #(.BYTES(1), .USER_W(2), .PKT_LEN(LEN), .PAUSE_CNT(P2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .s_tdata(dat[1]), .s_tvalid(vld[1]), .s_tlast(lst[1]),
    .s_tuser(usr[1]), .s_tready(rdy_o[1]), .enable(enable), .clr(clr),
    .pkt_cnt(pkt_o[1]), .beat_cnt(beat_o[1]), .err_cnt(err_o[1]), .err_flag(flag_o[1])
  );

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: ready is "enabled, past the first edge, no pause pending";
  // checker state follows the pattern/framing rules directly.
  bit                m_armed;
  bit                m_rdy  [2];
  int                m_pl   [2];
  logic [7:0]        m_exp  [2];
  int                m_idx  [2];
  longint unsigned   m_pkt  [2];
  longint unsigned   m_beat [2];
  longint unsigned   m_err  [2];
  bit                m_flag [2];
  localparam longint unsigned SAT = 64'hFFFF_FFFF;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_armed <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_rdy[i] <= 1'b0; m_pl[i] <= 0; m_exp[i] <= 8'd0; m_idx[i] <= 0;
        m_pkt[i] <= 0; m_beat[i] <= 0; m_err[i] <= 0; m_flag[i] <= 1'b0;
      end
    end else begin
      m_armed <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        bit acc, bad;
        int p;
        p   = (i == 0) ? P0 : P2;
        acc = vld[i] && m_rdy[i];
        bad = (dat[i] != m_exp[i]) || (usr[i][0] != (m_idx[i] == 0)) ||
              (lst[i] != (m_idx[i] == LEN - 1));
        if (clr) begin
          m_exp[i] <= 8'd0; m_idx[i] <= 0; m_pkt[i] <= 0; m_beat[i] <= 0;
          m_err[i] <= 0; m_flag[i] <= 1'b0;
        end else if (acc) begin
          m_exp[i]  <= dat[i] + 8'd1;
          m_idx[i]  <= (lst[i] || m_idx[i] == LEN - 1) ? 0 : m_idx[i] + 1;
          m_beat[i] <= (m_beat[i] == SAT) ? SAT : m_beat[i] + 1;
          if (lst[i]) m_pkt[i] <= (m_pkt[i] == SAT) ? SAT : m_pkt[i] + 1;
          if (bad) begin
            m_err[i]  <= (m_err[i] == SAT) ? SAT : m_err[i] + 1;
            m_flag[i] <= 1'b1;
          end
        end
        if (!enable) begin
          m_rdy[i] <= 1'b0; m_pl[i] <= 0;
        end else if (!m_armed) begin
          m_rdy[i] <= 1'b0;
        end else if (acc && p > 0) begin
          m_rdy[i] <= 1'b0; m_pl[i] <= p;
        end else if (m_pl[i] > 0) begin
          m_pl[i]  <= m_pl[i] - 1;
          m_rdy[i] <= (m_pl[i] == 1);
        end else begin
          m_rdy[i] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("model_tready%0d", i), rdy_o[i],  m_rdy[i]);
      chk($sformatf("model_pkt%0d", i),    pkt_o[i],  m_pkt[i]);
      chk($sformatf("model_beat%0d", i),   beat_o[i], m_beat[i]);
      chk($sformatf("model_err%0d", i),    err_o[i],  m_err[i]);
      chk($sformatf("model_flag%0d", i),   flag_o[i], m_flag[i]);
    end
  end

  // Paused instance: tvalid held high, mostly-correct random traffic.
  initial begin
    vld[1] = 1'b0; dat[1] = 8'd0; lst[1] = 1'b0; usr[1] = 2'd0;
    forever begin
      @(posedge clk); #1;
      vld[1] = 1'b1;
      dat[1] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : m_exp[1];
      usr[1] = {1'($urandom), ($urandom_range(0, 5) == 0) ? 1'($urandom) : (m_idx[1] == 0)};
      lst[1] = ($urandom_range(0, 5) == 0) ? 1'($urandom) : (m_idx[1] == LEN - 1);
    end
  end

  task automatic realign();
    @(posedge clk); #1;
  endtask

  task automatic beat0(input logic [7:0] d, input bit u, input bit l);
    int n;
    n = 0;
    dat[0] = d; usr[0] = {1'($urandom), u}; lst[0] = l; vld[0] = 1'b1;
    @(negedge clk);
    while (!rdy_o[0] && n < 20) begin
      n++; stalls0++;
      @(negedge clk);
    end
    if (n >= 20) chk("beat0_accept_timeout", 0, 1);
    realign();
    vld[0] = 1'b0;
  endtask

  task automatic check_counts(input string tag, input longint unsigned p, input longint unsigned b,
                              input longint unsigned e, input bit f);
    @(negedge clk);
    chk({tag, "_pkt"},  pkt_o[0],  p);
    chk({tag, "_beat"}, beat_o[0], b);
    chk({tag, "_err"},  err_o[0],  e);
    chk({tag, "_flag"}, flag_o[0], f);
    realign();
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    realign();
    clr = 1'b0;
  endtask

  task automatic release_reset(input string tag);
    reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk({tag, "_tready_edge1"}, rdy_o[0], 0);
    @(posedge clk); @(negedge clk);
    chk({tag, "_tready_edge2"}, rdy_o[0], 1);
    realign();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    longint unsigned b0;
    int n;
    vld[0] = 1'b0; dat[0] = 8'd0; lst[0] = 1'b0; usr[0] = 2'd0;
    #2 reset_n = 1'b0;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_tready%0d", i), rdy_o[i], 0);
      chk($sformatf("reset_pkt%0d", i),    pkt_o[i], 0);
      chk($sformatf("reset_beat%0d", i),   beat_o[i], 0);
      chk($sformatf("reset_err%0d", i),    err_o[i], 0);
      chk($sformatf("reset_flag%0d", i),   flag_o[i], 0);
    end
    realign();
    release_reset("rst1");

    // three clean packets, back-to-back
    stalls0 = 0;
    for (int i = 0; i < 12; i++) beat0(8'(i), (i % 4) == 0, (i % 4) == 3);
    chk("clean_tready_drops", stalls0, 0);
    check_counts("clean", 3, 12, 0, 0);

    // data jump 1->5, resync on 5
    pulse_clr();
    check_counts("clr1", 0, 0, 0, 0);
    beat0(8'd0, 1, 0); beat0(8'd1, 0, 0); beat0(8'd5, 0, 0); beat0(8'd6, 0, 1);
    check_counts("jump", 1, 4, 1, 1);

    // short packet with wrong tuser on the closing beat
    pulse_clr();
    beat0(8'd0, 1, 0); beat0(8'd1, 0, 0); beat0(8'd2, 1, 1);
    check_counts("short", 1, 3, 1, 1);
    beat0(8'd3, 1, 0); beat0(8'd4, 0, 0); beat0(8'd5, 0, 0); beat0(8'd6, 0, 1);
    check_counts("after_short", 2, 7, 1, 1);

    // FF wraps to 00 cleanly
    pulse_clr();
    beat0(8'hFD, 1, 0); beat0(8'hFE, 0, 0); beat0(8'hFF, 0, 0); beat0(8'h00, 0, 1);
    beat0(8'h01, 1, 0); beat0(8'h02, 0, 0); beat0(8'h03, 0, 0); beat0(8'h04, 0, 1);
    check_counts("wrap", 2, 8, 1, 1);

    // clr coinciding with an accepted beat discards it
    dat[0] = 8'h55; usr[0] = 2'b01; lst[0] = 1'b0; vld[0] = 1'b1; clr = 1'b1;
    @(negedge clk);
    chk("clr_beat_tready", rdy_o[0], 1);
    realign();
    clr = 1'b0; vld[0] = 1'b0;
    check_counts("clr_beat", 0, 0, 0, 0);
    beat0(8'd0, 1, 0); beat0(8'd1, 0, 0); beat0(8'd2, 0, 0); beat0(8'd3, 0, 1);
    check_counts("post_clr_beat", 1, 4, 0, 0);

    // asynchronous reset in the middle of a packet
    pulse_clr();
    beat0(8'd0, 1, 0); beat0(8'd1, 0, 0);
    dat[0] = 8'd2; usr[0] = 2'b00; lst[0] = 1'b0; vld[0] = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_tready", rdy_o[0], 0);
    chk("midrst_beat",   beat_o[0], 0);
    chk("midrst_pkt",    pkt_o[0], 0);
    chk("midrst_err",    err_o[0], 0);
    chk("midrst_flag",   flag_o[0], 0);
    vld[0] = 1'b0;
    repeat (2) realign();
    release_reset("rst2");
    beat0(8'd0, 1, 0); beat0(8'd1, 0, 0); beat0(8'd2, 0, 0); beat0(8'd3, 0, 1);
    check_counts("post_rst", 1, 4, 0, 0);

    // pause pattern on the PAUSE_CNT=2 instance with tvalid held high
    n = 0;
    @(negedge clk);
    while (!rdy_o[1] && n < 10) begin n++; @(negedge clk); end
    chk("pause_found_ready", rdy_o[1], 1);
    b0 = beat_o[1];
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("pause_pattern%0d", k), rdy_o[1], (k % 3) == 0);
      @(negedge clk);
    end
    chk("pause_beats_in_9", beat_o[1] - b0, 3);
    realign();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      enable = ($urandom_range(0, 49) != 0);
      clr    = ($urandom_range(0, 149) == 0);
      vld[0] = ($urandom_range(0, 3) != 0);
      dat[0] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : m_exp[0];
      usr[0] = {1'($urandom), ($urandom_range(0, 9) == 0) ? 1'($urandom) : (m_idx[0] == 0)};
      lst[0] = ($urandom_range(0, 9) == 0) ? 1'($urandom) : (m_idx[0] == LEN - 1);
      if (c == 1500) reset_n = 1'b0;
      if (c == 1503) reset_n = 1'b1;
      realign();
    end
    enable = 1'b1; clr = 1'b0; vld[0] = 1'b0;
    repeat (3) realign();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
